spi_receiver: RTL and testbench

SPI_RECEIVER -- requirements
Module: spi_receiver

---
 rtl/spi_pkg.sv | 20 ++
 rtl/sync2.sv | 25 ++
 rtl/spi_receiver.sv | 129 ++++++++++++
 tb/tb_spi_receiver.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM states and the default link parameters
// used by both the transmitter and the receiver.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam int SPI_DATA_WIDTH = 8;
    localparam bit SPI_CS_POLAR   = 1'b0;
    localparam bit SPI_CPOL       = 1'b0;
    localparam bit SPI_CPHA       = 1'b0;

    // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling one.
    function automatic logic sample_on_rising(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing one asynchronous SPI line into the system clock domain.
module sync2
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_receiver.sv
// SPI slave receiver: oversamples SCK/MOSI/CS with clk_100 and delivers complete
// words through a valid/ready handshake with sticky overrun and framing flags.
module spi_receiver
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH = SPI_DATA_WIDTH,
    parameter bit P_CS_POLAR   = SPI_CS_POLAR,
    parameter bit P_CPOL       = SPI_CPOL,
    parameter bit P_CPHA       = SPI_CPHA
) (
    input  logic                    clk_100,
    input  logic                    s_rst,
    input  logic                    SCK,
    input  logic                    MOSI,
    input  logic                    CS,
    output logic [P_DATA_WIDTH-1:0] data,
    output logic                    valid,
    input  logic                    ready,
    output logic                    overrun,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int                CNT_W       = $clog2(P_DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(P_DATA_WIDTH);
    localparam logic              SAMPLE_RISE = sample_on_rising(P_CPOL, P_CPHA);

    logic sck_s;
    logic mosi_s;
    logic cs_s;
    logic sck_prev;

    spi_state_t state_q;
    spi_state_t state_d;

    logic [CNT_W-1:0]        bit_cnt;
    logic [P_DATA_WIDTH-1:0] shift_reg;

    logic sample_edge;
    logic cs_sel;
    logic word_done;
    logic cs_drop;

    sync2 #(.RST_VAL(P_CPOL)) u_sync_sck (
        .clk (clk_100),
        .rst (s_rst),
        .d   (SCK),
        .q   (sck_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk_100),
        .rst (s_rst),
        .d   (MOSI),
        .q   (mosi_s)
    );

    sync2 #(.RST_VAL(!P_CS_POLAR)) u_sync_cs (
        .clk (clk_100),
        .rst (s_rst),
        .d   (CS),
        .q   (cs_s)
    );

    assign sample_edge = SAMPLE_RISE ? (sck_s & ~sck_prev) : (~sck_s & sck_prev);
    assign cs_sel      = (cs_s == P_CS_POLAR);
    assign word_done   = (state_q == ACTIVE) && (bit_cnt == CNT_FULL);
    assign cs_drop     = (state_q == ACTIVE) && !cs_sel;
    assign busy        = (state_q == ACTIVE);

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_sel)  state_d = ACTIVE;
            ACTIVE:  if (!cs_sel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A word that has just filled the counter is complete, so a CS release in
    // that cycle ends the frame cleanly instead of flagging a framing error.
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            sck_prev  <= P_CPOL;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sck_prev <= sck_s;

            if (state_q == IDLE) begin
                bit_cnt <= '0;
            end else if (cs_drop) begin
                bit_cnt <= '0;
                if ((bit_cnt != '0) && !word_done) begin
                    frame_err <= 1'b1;
                end
            end else if (sample_edge) begin
                shift_reg <= P_DATA_WIDTH'({shift_reg, mosi_s});
                bit_cnt   <= word_done ? CNT_W'(1) : bit_cnt + 1'b1;
            end else if (word_done) begin
                bit_cnt <= '0;
            end

            if (word_done) begin
                if (!valid || ready) begin
                    data  <= shift_reg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_receiver.sv
// Randomized bench for spi_receiver: a behavioural SPI master drives the DUTs and a
// word scoreboard plus latency/handshake monitor checks what comes out.
module tb_spi_receiver;

    logic       clk_100;
    logic       s_rst;
    logic       sck_l  [2];
    logic       mosi_l [2];
    logic       cs_l   [2];
    logic [7:0] data0;
    logic [7:0] data1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       overrun0, overrun1;
    logic       frame_err0, frame_err1;
    logic       busy0, busy1;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         last_edge_cyc = 0;
    bit         rand_ready = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] tx_q  [$];

    spi_receiver dut (
        .clk_100   (clk_100),
        .s_rst     (s_rst),
        .SCK       (sck_l[0]),
        .MOSI      (mosi_l[0]),
        .CS        (cs_l[0]),
        .data      (data0),
        .valid     (valid0),
        .ready     (ready0),
        .overrun   (overrun0),
        .frame_err (frame_err0),
        .busy      (busy0)
    );

    spi_receiver #(
        .P_DATA_WIDTH (8),
        .P_CS_POLAR   (1'b0),
        .P_CPOL       (1'b1),
        .P_CPHA       (1'b1)
    ) dut_mode3 (
        .clk_100   (clk_100),
        .s_rst     (s_rst),
        .SCK       (sck_l[1]),
        .MOSI      (mosi_l[1]),
        .CS        (cs_l[1]),
        .data      (data1),
        .valid     (valid1),
        .ready     (ready1),
        .overrun   (overrun1),
        .frame_err (frame_err1),
        .busy      (busy1)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    always @(posedge clk_100) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100);
        #2;
    endtask

    // SPI master: half SCK period of two system clocks gives SCK = clk_100/4.
    // Instance 0 runs mode 0, instance 1 runs mode 3.
    task automatic applyStimulus(input int sel, input logic [7:0] value, input int nbits);
        logic cpol;
        logic cpha;
        logic [7:0] v;
        cpol = (sel == 1);
        cpha = (sel == 1);
        v    = value;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi_l[sel] = v[7 - i];
                tick(2);
                sck_l[sel] = ~cpol;
                if (i == 7) last_edge_cyc = cyc;
                tick(2);
                sck_l[sel] = cpol;
            end else begin
                sck_l[sel]  = ~cpol;
                mosi_l[sel] = v[7 - i];
                tick(2);
                sck_l[sel] = cpol;
                if (i == 7) last_edge_cyc = cyc;
                tick(2);
            end
        end
    endtask

    task automatic send_frame(input int sel, input bit expect_words);
        cs_l[sel] = 1'b0;
        tick(2);
        foreach (tx_q[k]) begin
            if (expect_words) exp_q.push_back(tx_q[k]);
            applyStimulus(sel, tx_q[k], 8);
        end
        tick(2);
        cs_l[sel] = 1'b1;
        tick(4);
    endtask

    initial begin
        forever begin
            @(posedge clk_100);
            #2;
            if (rand_ready) ready0 = 1'($urandom_range(0, 1));
        end
    end

    // Every accepted word must be the oldest one sent, valid must rise exactly four
    // system cycles after the raw final sampling edge, and drop right after a handshake.
    initial begin
        bit prev_valid;
        bit pending_hs;
        prev_valid = 1'b0;
        pending_hs = 1'b0;
        forever begin
            @(negedge clk_100);
            if (s_rst) begin
                prev_valid = 1'b0;
                pending_hs = 1'b0;
            end else begin
                if (pending_hs) begin
                    checkOutput("valid_drop", {31'd0, valid0}, 32'd0);
                    pending_hs = 1'b0;
                end
                if (valid0 && !prev_valid)
                    checkOutput("valid_latency", 32'(cyc - last_edge_cyc), 32'd4);
                if (valid0 && ready0) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("spurious_valid", {31'd0, valid0}, 32'd0);
                    end else begin
                        checkOutput("data", {24'd0, data0}, {24'd0, exp_q.pop_front()});
                    end
                    pending_hs = 1'b1;
                end
                prev_valid = valid0;
            end
        end
    end

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] partial;
        int         nwords;

        s_rst     = 1'b1;
        sck_l[0]  = 1'b0;
        sck_l[1]  = 1'b1;
        mosi_l[0] = 1'b0;
        mosi_l[1] = 1'b0;
        cs_l[0]   = 1'b1;
        cs_l[1]   = 1'b1;
        ready0    = 1'b1;
        ready1    = 1'b0;

        tick(3);
        checkOutput("rst_data", {24'd0, data0}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid0}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun0}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err0}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy0}, 32'd0);
        s_rst = 1'b0;
        tick(4);

        $display("[TB] single word 0xF0");
        tx_q.delete();
        tx_q.push_back(8'hF0);
        send_frame(0, 1'b1);
        checkOutput("f0_valid", {31'd0, valid0}, 32'd0);
        checkOutput("f0_overrun", {31'd0, overrun0}, 32'd0);
        checkOutput("f0_frame_err", {31'd0, frame_err0}, 32'd0);
        checkOutput("f0_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] back-to-back 0xA5 0x3C");
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        send_frame(0, 1'b1);
        checkOutput("b2b_left", 32'(exp_q.size()), 32'd0);
        checkOutput("b2b_frame_err", {31'd0, frame_err0}, 32'd0);

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            nwords = $urandom_range(1, 3);
            tx_q.delete();
            for (int w = 0; w < nwords; w++) tx_q.push_back(8'($urandom));
            rand_ready = (f >= 3);
            send_frame(0, 1'b1);
            tick($urandom_range(0, 5));
        end
        rand_ready = 1'b0;
        ready0     = 1'b1;
        tick(8);
        checkOutput("rand_left", 32'(exp_q.size()), 32'd0);
        checkOutput("rand_overrun", {31'd0, overrun0}, 32'd0);
        checkOutput("rand_frame_err", {31'd0, frame_err0}, 32'd0);

        $display("[TB] overrun with ready low");
        ready0 = 1'b0;
        tx_q.delete();
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        send_frame(0, 1'b0);
        checkOutput("ovr_valid", {31'd0, valid0}, 32'd1);
        checkOutput("ovr_data", {24'd0, data0}, 32'h11);
        checkOutput("ovr_flag", {31'd0, overrun0}, 32'd1);
        exp_q.push_back(8'h11);
        ready0 = 1'b1;
        tick(4);
        checkOutput("ovr_left", 32'(exp_q.size()), 32'd0);
        checkOutput("ovr_valid_after", {31'd0, valid0}, 32'd0);
        checkOutput("ovr_sticky", {31'd0, overrun0}, 32'd1);
        s_rst = 1'b1;
        tick(2);
        s_rst = 1'b0;
        tick(4);
        checkOutput("ovr_cleared", {31'd0, overrun0}, 32'd0);

        $display("[TB] CS released after 5 bits");
        partial  = 8'($urandom);
        cs_l[0]  = 1'b0;
        tick(2);
        applyStimulus(0, partial, 5);
        tick(1);
        checkOutput("partial_busy", {31'd0, busy0}, 32'd1);
        tick(1);
        cs_l[0] = 1'b1;
        tick(4);
        checkOutput("ferr_flag", {31'd0, frame_err0}, 32'd1);
        checkOutput("ferr_valid", {31'd0, valid0}, 32'd0);
        checkOutput("ferr_busy", {31'd0, busy0}, 32'd0);
        tx_q.delete();
        tx_q.push_back(8'h55);
        send_frame(0, 1'b1);
        checkOutput("ferr_next_left", 32'(exp_q.size()), 32'd0);
        checkOutput("ferr_next_data", {24'd0, data0}, 32'h55);
        checkOutput("ferr_sticky", {31'd0, frame_err0}, 32'd1);

        $display("[TB] reset mid-frame");
        cs_l[0] = 1'b0;
        tick(2);
        applyStimulus(0, 8'hFF, 4);
        s_rst = 1'b1;
        @(posedge clk_100);
        @(negedge clk_100);
        checkOutput("mid_rst_data", {24'd0, data0}, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, valid0}, 32'd0);
        checkOutput("mid_rst_overrun", {31'd0, overrun0}, 32'd0);
        checkOutput("mid_rst_frame_err", {31'd0, frame_err0}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy0}, 32'd0);
        cs_l[0] = 1'b1;
        tick(2);
        s_rst = 1'b0;
        tick(4);
        tx_q.delete();
        tx_q.push_back(8'h81);
        send_frame(0, 1'b1);
        checkOutput("post_rst_left", 32'(exp_q.size()), 32'd0);
        checkOutput("post_rst_data", {24'd0, data0}, 32'h81);
        checkOutput("post_rst_frame_err", {31'd0, frame_err0}, 32'd0);

        $display("[TB] mode 3 word 0xC3");
        tx_q.delete();
        tx_q.push_back(8'hC3);
        send_frame(1, 1'b0);
        checkOutput("m3_data", {24'd0, data1}, 32'hC3);
        checkOutput("m3_valid", {31'd0, valid1}, 32'd1);
        checkOutput("m3_overrun", {31'd0, overrun1}, 32'd0);
        checkOutput("m3_frame_err", {31'd0, frame_err1}, 32'd0);
        checkOutput("m3_busy", {31'd0, busy1}, 32'd0);
        ready1 = 1'b1;
        tick(2);
        checkOutput("m3_valid_after", {31'd0, valid1}, 32'd0);

        tick(4);
        checkOutput("final_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
